ex_stage_ctrl: RTL and testbench
================================

Name: ex_stage_ctrl

Overview:
- Execute-stage controller for the 16-bit ALU in the 5-stage pipeline.
- Accepts decoded instructions from ID/EX over a valid/ready handshake and decodes the 5-bit opcode into the ALU's 13-bit one-hot operation vector.
- Drives ALU operands, owns the condition-code register (CCR), and registers results into the EX/MEM slot with backpressure and flush support.

Parameters:
- DW, 16, datapath width (ALU operand/result width).
- RW, 3, register-destination index width.
- CNTW, 16, retired-instruction counter width.

Ports:
- clk  input  1  pipeline clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- flush  input  1  kill the incoming instruction and the EX/MEM slot.
- in_valid  input  1  ID/EX instruction valid.
- in_ready  output  1  controller can accept this cycle.
- in_opcode  input  5  instruction opcode.
- in_src1  input  DW  operand 1, already forwarded; carries the in-port value for IN.
- in_src2  input  DW  operand 2.
- in_shamt  input  4  shift amount.
- in_rdst  input  RW  destination register.
- alu_operation  output  13  one-hot ALU operation, combinational.
- alu_op1, alu_op2  output  DW  ALU operands, combinational.
- alu_shamt  output  4  ALU shift amount.
- alu_result  input  DW  ALU result.
- alu_flag  input  3  ALU flags: [0]=Z, [2]=C.
- out_valid  output  1  EX/MEM slot valid.
- out_ready  input  1  downstream accepts the slot.
- out_result  output  DW  registered result.
- out_rdst  output  RW  registered destination.
- out_wb_en  output  1  register write-back enable.
- out_port_en  output  1  OUT-port write strobe qualifier.
- ccr  output  3  {C,N,Z}: [0]=Z, [1]=N, [2]=C.
- illegal  output  1  sticky flag, set on any illegal opcode.
- retired_cnt  output  CNTW  count of accepted non-NOP instructions.

Behaviour:
- Reset values: out_valid=0; out_result=0; out_rdst=0; out_wb_en=0; out_port_en=0; ccr=0; illegal=0; retired_cnt=0. Registers clear immediately on rst assertion, including mid-transfer.
- Opcode to alu_operation bit:
  - 0 NOP→10; 1 SETC→none; 2 CLRC→none; 3 NOT→9; 4 INC→1; 5 DEC→0; 6 OUT→12; 7 IN→11.
  - 8 MOV→8; 9 ADD→7; 10 SUB→6; 11 AND→5; 12 OR→4; 13 SHL→3; 14 SHR→2.
  - 15-31 are illegal: treated as NOP and set `illegal`.
- ALU drive: alu_operation=0 whenever in_valid=0 or flush=1. Operands pass through from in_*.
- FSM, two states:
  - EMPTY (out_valid=0) and FULL (out_valid=1).
  - in_ready = !out_valid || out_ready, forced 0 while flush=1.
  - Accept = in_valid && in_ready.
  - EMPTY→FULL on accept.
  - FULL→EMPTY on out_ready without accept.
  - FULL stays FULL on accept with out_ready (back-to-back, one instruction per cycle).
  - FULL holds all out_* unchanged while out_ready=0.
- Latency: 1 cycle from accept to out_valid.
- out_result by opcode: IN and OUT capture in_src1; SETC, CLRC and NOP capture 0; all others capture alu_result.
- out_wb_en=1 for NOT, INC, DEC, IN, MOV, ADD, SUB, AND, OR, SHL, SHR; 0 otherwise.
- out_port_en=1 only for OUT.
- CCR updates at accept, i.e. visible the cycle after accept:
  - NOT, AND, OR, MOV-free ops: Z=alu_flag[0], N=alu_result[15], C unchanged.
  - ADD, INC, SHL, SHR: Z, N as above; C=alu_flag[2].
  - SUB, DEC: Z, N as above; C unchanged.
  - SETC: C=1. CLRC: C=0. Other opcodes: no change.
  - N always comes from alu_result[15]; alu_flag[1] is ignored.
- retired_cnt increments on every accept except NOP or illegal, and wraps from 2^CNTW-1 to 0.
- Flush:
  - Next cycle out_valid=0.
  - No accept that cycle, so no CCR, counter or illegal update.
  - Flush overrides a simultaneous in_valid and out_ready.

Optional Feature:
- Macro: CCR_SAVE_EN.
- When defined, adds inputs int_save and rti_restore (1 bit each) and a 3-bit shadow register, reset to 0.
  - int_save copies ccr into the shadow.
  - rti_restore loads ccr from the shadow.
  - rti_restore beats an accept-driven CCR update in the same cycle.
  - int_save samples ccr as it was before that cycle's update.
- When undefined: the ports and shadow register are absent; CCR is written only by accepts.

Test Plan:
- ADD src1=0xFFFF, src2=0x0001, out_ready=1 -> alu_operation=0x0080; next cycle out_result=0x0000, ccr=3'b101, out_wb_en=1, retired_cnt=1.
- CLRC, then SUB src1=5, src2=7 -> out_result=0xFFFE, ccr=3'b010, C stays 0.
- out_ready=0 with 3 back-to-back INCs starting from 0x0010 -> in_ready=0 after the first; out_result held at 0x0011; releasing out_ready drains 0x0011 then the next instruction; retired_cnt ends at 3.
- Opcode 0x1F -> alu_operation=0, illegal=1 (stays set), out_wb_en=0, ccr unchanged, retired_cnt unchanged.
- flush asserted with in_valid=1 while FULL -> out_valid=0 next cycle, ccr unchanged; rst asserted mid-stream -> all outputs 0 immediately.
- CCR_SAVE_EN: ccr=3'b100, pulse int_save, then ADD 1+1 (ccr=3'b000), then rti_restore -> ccr=3'b100.

Source files
------------

// File: rtl/ex_stage_ctrl_if.sv
// ex_stage_ctrl_if: ID/EX handshake, ALU drive and EX/MEM slot signals of the execute-stage controller
interface ex_stage_ctrl_if #(
    parameter int DW   = 16,
    parameter int RW   = 3,
    parameter int CNTW = 16
);
    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [4:0]      in_opcode;
    logic [DW-1:0]   in_src1;
    logic [DW-1:0]   in_src2;
    logic [3:0]      in_shamt;
    logic [RW-1:0]   in_rdst;
    logic [12:0]     alu_operation;
    logic [DW-1:0]   alu_op1;
    logic [DW-1:0]   alu_op2;
    logic [3:0]      alu_shamt;
    logic [DW-1:0]   alu_result;
    logic [2:0]      alu_flag;
    logic            out_valid;
    logic            out_ready;
    logic [DW-1:0]   out_result;
    logic [RW-1:0]   out_rdst;
    logic            out_wb_en;
    logic            out_port_en;
    logic [2:0]      ccr;
    logic            illegal;
    logic [CNTW-1:0] retired_cnt;

    modport slave (
        input  flush, in_valid, in_opcode, in_src1, in_src2, in_shamt, in_rdst,
               alu_result, alu_flag, out_ready,
        output in_ready, alu_operation, alu_op1, alu_op2, alu_shamt,
               out_valid, out_result, out_rdst, out_wb_en, out_port_en,
               ccr, illegal, retired_cnt
    );

    modport master (
        output flush, in_valid, in_opcode, in_src1, in_src2, in_shamt, in_rdst,
               alu_result, alu_flag, out_ready,
        input  in_ready, alu_operation, alu_op1, alu_op2, alu_shamt,
               out_valid, out_result, out_rdst, out_wb_en, out_port_en,
               ccr, illegal, retired_cnt
    );
endinterface

// File: rtl/ex_stage_ctrl.sv
// ex_stage_ctrl: EX-stage controller - opcode decode, CCR, EX/MEM slot with backpressure/flush.
// Define CCR_SAVE_EN to add the int_save/rti_restore CCR shadow register.
module ex_stage_ctrl #(
    parameter int DW   = 16,
    parameter int RW   = 3,
    parameter int CNTW = 16
) (
    input  logic clk,
    input  logic rst,
`ifdef CCR_SAVE_EN
    input  logic int_save,
    input  logic rti_restore,
`endif
    ex_stage_ctrl_if.slave bus
);
    typedef enum logic {EMPTY, FULL} state_t;

    state_t          state, state_nx;
    logic [4:0]      op;
    logic            legal, accept, zn_upd, c_upd;
    logic [12:0]     op_sel;
    logic [2:0]      ccr_q, ccr_acc;
    logic [DW-1:0]   result_q, result_nx;
    logic [RW-1:0]   rdst_q;
    logic            wb_q, port_q, illegal_q;
    logic [CNTW-1:0] cnt_q;

    assign op     = bus.in_opcode;
    assign legal  = op < 5'd15;
    assign accept = bus.in_valid && bus.in_ready;

    always_ff @(posedge clk or posedge rst)
        if (rst) state <= EMPTY;
        else state <= state_nx;

    always_comb state_nx = accept ? FULL : (bus.out_ready || bus.flush) ? EMPTY : state;

    always_comb begin
        bus.out_valid = state == FULL;
        bus.in_ready  = (state == EMPTY || bus.out_ready) && !bus.flush;
    end

    always_comb begin
        op_sel = '0;
        case (op)
            5'd0:    op_sel = 13'h0400;
            5'd3:    op_sel = 13'h0200;
            5'd4:    op_sel = 13'h0002;
            5'd5:    op_sel = 13'h0001;
            5'd6:    op_sel = 13'h1000;
            5'd7:    op_sel = 13'h0800;
            5'd8:    op_sel = 13'h0100;
            5'd9:    op_sel = 13'h0080;
            5'd10:   op_sel = 13'h0040;
            5'd11:   op_sel = 13'h0020;
            5'd12:   op_sel = 13'h0010;
            5'd13:   op_sel = 13'h0008;
            5'd14:   op_sel = 13'h0004;
            default: op_sel = '0;
        endcase
    end

    assign bus.alu_operation = (bus.in_valid && !bus.flush) ? op_sel : '0;
    assign bus.alu_op1       = bus.in_src1;
    assign bus.alu_op2       = bus.in_src2;
    assign bus.alu_shamt     = bus.in_shamt;

    // Z/N follow the ALU for logic/arith ops; C only for carry-producing ops
    assign zn_upd     = op inside {5'd3, 5'd4, 5'd5, 5'd9, 5'd10, 5'd11, 5'd12, 5'd13, 5'd14};
    assign c_upd      = op inside {5'd4, 5'd9, 5'd13, 5'd14};
    assign ccr_acc[0] = zn_upd ? bus.alu_flag[0] : ccr_q[0];
    assign ccr_acc[1] = zn_upd ? bus.alu_result[DW-1] : ccr_q[1];
    assign ccr_acc[2] = op == 5'd1 ? 1'b1 : op == 5'd2 ? 1'b0 : c_upd ? bus.alu_flag[2] : ccr_q[2];
    assign result_nx  = (op == 5'd6 || op == 5'd7) ? bus.in_src1 :
                        (op <= 5'd2 || !legal) ? '0 : bus.alu_result;

`ifdef CCR_SAVE_EN
    logic [2:0] shadow_q;

    always_ff @(posedge clk or posedge rst)
        if (rst) shadow_q <= '0;
        else if (int_save) shadow_q <= ccr_q;

    always_ff @(posedge clk or posedge rst)
        if (rst) ccr_q <= '0;
        else if (rti_restore) ccr_q <= shadow_q;
        else if (accept) ccr_q <= ccr_acc;
`else
    always_ff @(posedge clk or posedge rst)
        if (rst) ccr_q <= '0;
        else if (accept) ccr_q <= ccr_acc;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result_q  <= '0;
            rdst_q    <= '0;
            wb_q      <= 1'b0;
            port_q    <= 1'b0;
            illegal_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            if (accept) begin
                result_q <= result_nx;
                rdst_q   <= bus.in_rdst;
                wb_q     <= op inside {5'd3, 5'd4, 5'd5, 5'd7, 5'd8, 5'd9, 5'd10, 5'd11, 5'd12, 5'd13, 5'd14};
                port_q   <= op == 5'd6;
            end
            if (accept && !legal) illegal_q <= 1'b1;
            if (accept && legal && op != 5'd0) cnt_q <= cnt_q + 1'b1;
        end
    end

    assign bus.out_result  = result_q;
    assign bus.out_rdst    = rdst_q;
    assign bus.out_wb_en   = wb_q;
    assign bus.out_port_en = port_q;
    assign bus.ccr         = ccr_q;
    assign bus.illegal     = illegal_q;
    assign bus.retired_cnt = cnt_q;
endmodule

// File: tb/tb_ex_stage_ctrl.sv
// tb_ex_stage_ctrl: scoreboard bench for ex_stage_ctrl with a behavioural ALU.
module tb_ex_stage_ctrl;
    localparam int DW = 16, RW = 3, CNTW = 4;

    typedef struct packed {
        logic [DW-1:0] result;
        logic [RW-1:0] rdst;
        logic          wb_en;
        logic          port_en;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
`ifdef CCR_SAVE_EN
    logic int_save = 1'b0, rti_restore = 1'b0;
`endif
    int checks = 0, failures = 0;
    exp_t sb[$];
    logic [2:0]      exp_ccr = '0;
    logic [CNTW-1:0] exp_cnt = '0;
    logic            exp_ill = 1'b0;
    logic [DW:0]     alu_w;

    ex_stage_ctrl_if #(.DW(DW), .RW(RW), .CNTW(CNTW)) bus();

    ex_stage_ctrl #(.DW(DW), .RW(RW), .CNTW(CNTW)) dut (
        .clk(clk),
        .rst(rst),
`ifdef CCR_SAVE_EN
        .int_save(int_save),
        .rti_restore(rti_restore),
`endif
        .bus(bus)
    );

    always #5 clk = ~clk;

    // ALU stand-in; unused ops return 0xBEEF so the controller must not pass it through
    always_comb begin
        alu_w = {1'b0, 16'hBEEF};
        if (bus.alu_operation[7]) alu_w = {1'b0, bus.alu_op1} + {1'b0, bus.alu_op2};
        else if (bus.alu_operation[6]) alu_w = {1'b0, bus.alu_op1} - {1'b0, bus.alu_op2};
        else if (bus.alu_operation[1]) alu_w = {1'b0, bus.alu_op1} + 17'd1;
        else if (bus.alu_operation[0]) alu_w = {1'b0, bus.alu_op1} - 17'd1;
        else if (bus.alu_operation[9]) alu_w = {1'b0, ~bus.alu_op1};
        else if (bus.alu_operation[5]) alu_w = {1'b0, bus.alu_op1 & bus.alu_op2};
        else if (bus.alu_operation[4]) alu_w = {1'b0, bus.alu_op1 | bus.alu_op2};
        else if (bus.alu_operation[8]) alu_w = {1'b0, bus.alu_op1};
        else if (bus.alu_operation[3]) alu_w = {1'b0, bus.alu_op1} << bus.alu_shamt;
        else if (bus.alu_operation[2])
            alu_w = {bus.alu_shamt != 4'd0 ? bus.alu_op1[bus.alu_shamt - 4'd1] : 1'b0, bus.alu_op1 >> bus.alu_shamt};
    end
    assign bus.alu_result = alu_w[15:0];
    assign bus.alu_flag   = {alu_w[16], alu_w[15], alu_w[15:0] == 16'd0};

    function automatic logic [DW:0] golden(input logic [4:0] op, input logic [DW-1:0] a,
                                           input logic [DW-1:0] b, input logic [3:0] sh);
        logic [DW:0] r;
        case (op)
            5'd3:             r = {1'b0, ~a};
            5'd4:             r = {1'b0, a} + 17'd1;
            5'd5:             r = {1'b0, a} - 17'd1;
            5'd6, 5'd7, 5'd8: r = {1'b0, a};
            5'd9:             r = {1'b0, a} + {1'b0, b};
            5'd10:            r = {1'b0, a} - {1'b0, b};
            5'd11:            r = {1'b0, a & b};
            5'd12:            r = {1'b0, a | b};
            5'd13:            r = {1'b0, a} << sh;
            5'd14:            r = {sh != 4'd0 ? a[sh - 4'd1] : 1'b0, a >> sh};
            default:          r = '0;
        endcase
        return r;
    endfunction

    function automatic logic [12:0] onehot(input logic [4:0] op);
        case (op)
            5'd0:    return 13'h0400;
            5'd3:    return 13'h0200;
            5'd4:    return 13'h0002;
            5'd5:    return 13'h0001;
            5'd6:    return 13'h1000;
            5'd7:    return 13'h0800;
            5'd8:    return 13'h0100;
            5'd9:    return 13'h0080;
            5'd10:   return 13'h0040;
            5'd11:   return 13'h0020;
            5'd12:   return 13'h0010;
            5'd13:   return 13'h0008;
            5'd14:   return 13'h0004;
            default: return 13'h0000;
        endcase
    endfunction

    // Drives one instruction, waits for accept and records the expected slot and CCR/counter effects.
    task automatic send(input logic [4:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b,
                        input logic [3:0] sh, input logic [RW-1:0] rd);
        logic [DW:0] r;
        exp_t e;
        int n = 0;
        bus.in_valid = 1'b1; bus.in_opcode = op; bus.in_src1 = a; bus.in_src2 = b;
        bus.in_shamt = sh; bus.in_rdst = rd;
        #1;
        checks++;
        if (bus.alu_operation !== onehot(op)) begin
            failures++;
            $display("FAIL alu_operation op=%0d got=%h exp=%h", op, bus.alu_operation, onehot(op));
        end
        while (!bus.in_ready && n < 50) begin @(posedge clk); #2; n++; end
        if (n == 50) begin
            checks++; failures++;
            $display("FAIL accept_timeout op=%0d got in_ready=%b exp 1", op, bus.in_ready);
            bus.in_valid = 1'b0;
            return;
        end
        r = golden(op, a, b, sh);
        e.result = r[DW-1:0]; e.rdst = rd; e.port_en = op == 5'd6;
        e.wb_en = op inside {5'd3, 5'd4, 5'd5, 5'd7, 5'd8, 5'd9, 5'd10, 5'd11, 5'd12, 5'd13, 5'd14};
        sb.push_back(e);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        if (op inside {5'd3, 5'd5, 5'd10, 5'd11, 5'd12}) exp_ccr[1:0] = {r[15], r[15:0] == 16'd0};
        else if (op inside {5'd4, 5'd9, 5'd13, 5'd14}) exp_ccr = {r[16], r[15], r[15:0] == 16'd0};
        else if (op == 5'd1) exp_ccr[2] = 1'b1;
        else if (op == 5'd2) exp_ccr[2] = 1'b0;
        if (op < 5'd15 && op != 5'd0) exp_cnt = exp_cnt + 1'b1;
        if (op >= 5'd15) exp_ill = 1'b1;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst && bus.out_valid && bus.out_ready) begin
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL slot_unexpected got result=%h rdst=%0d exp no slot", bus.out_result, bus.out_rdst);
            end else begin
                e = sb.pop_front();
                if ({bus.out_result, bus.out_rdst, bus.out_wb_en, bus.out_port_en} !== e) begin
                    failures++;
                    $display("FAIL slot got result=%h rdst=%0d wb=%b port=%b exp result=%h rdst=%0d wb=%b port=%b",
                             bus.out_result, bus.out_rdst, bus.out_wb_en, bus.out_port_en,
                             e.result, e.rdst, e.wb_en, e.port_en);
                end
            end
        end
    end

    task automatic test_reset();
        checks++;
        if ({bus.out_valid, bus.out_result, bus.out_rdst, bus.out_wb_en, bus.out_port_en,
             bus.ccr, bus.illegal, bus.retired_cnt} !== '0) begin
            failures++;
            $display("FAIL reset_values got valid=%b result=%h ccr=%b ill=%b cnt=%0d exp all 0",
                     bus.out_valid, bus.out_result, bus.ccr, bus.illegal, bus.retired_cnt);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got %b exp 1", bus.in_ready); end
        checks++;
        if (bus.alu_operation !== 13'h0) begin
            failures++; $display("FAIL idle_alu_operation got %h exp 0", bus.alu_operation);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_add();
        bus.out_ready = 1'b1;
        send(5'd9, 16'hFFFF, 16'h0001, 4'd0, 3'd1);
        checks++;
        if (bus.ccr !== 3'b101) begin failures++; $display("FAIL add_ccr got %b exp 101", bus.ccr); end
        checks++;
        if (bus.retired_cnt !== 4'd1) begin failures++; $display("FAIL add_cnt got %0d exp 1", bus.retired_cnt); end
    endtask

    task automatic test_sub();
        send(5'd2, 16'h0000, 16'h0000, 4'd0, 3'd0);
        send(5'd10, 16'd5, 16'd7, 4'd0, 3'd2);
        checks++;
        if (bus.ccr !== 3'b010) begin failures++; $display("FAIL sub_ccr got %b exp 010", bus.ccr); end
    endtask

    task automatic test_backpressure();
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        send(5'd4, 16'h0010, 16'h0000, 4'd0, 3'd3);
        checks++;
        if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL bp_in_ready got %b exp 0", bus.in_ready); end
        fork
            begin
                send(5'd4, 16'h0011, 16'h0000, 4'd0, 3'd4);
                send(5'd4, 16'h0012, 16'h0000, 4'd0, 3'd5);
            end
            begin
                repeat (3) @(posedge clk);
                #1;
                checks++;
                if (bus.out_result !== 16'h0011 || bus.out_valid !== 1'b1) begin
                    failures++;
                    $display("FAIL bp_hold got result=%h valid=%b exp 0011 1", bus.out_result, bus.out_valid);
                end
                checks++;
                if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL bp_stall got %b exp 0", bus.in_ready); end
                bus.out_ready = 1'b1;
            end
        join
        checks++;
        if (bus.retired_cnt !== exp_cnt) begin
            failures++; $display("FAIL bp_cnt got %0d exp %0d", bus.retired_cnt, exp_cnt);
        end
    endtask

    task automatic test_illegal();
        logic [2:0] ccr_before;
        ccr_before = exp_ccr;
        send(5'h1F, 16'h1234, 16'h0001, 4'd0, 3'd6);
        checks++;
        if (bus.illegal !== 1'b1) begin failures++; $display("FAIL illegal_set got %b exp 1", bus.illegal); end
        checks++;
        if (bus.ccr !== ccr_before) begin failures++; $display("FAIL illegal_ccr got %b exp %b", bus.ccr, ccr_before); end
        checks++;
        if (bus.retired_cnt !== exp_cnt) begin
            failures++; $display("FAIL illegal_cnt got %0d exp %0d", bus.retired_cnt, exp_cnt);
        end
        send(5'd0, 16'h5555, 16'h0000, 4'd0, 3'd7);
        send(5'd20, 16'h0000, 16'h0000, 4'd0, 3'd1);
        checks++;
        if (bus.illegal !== exp_ill || bus.retired_cnt !== exp_cnt) begin
            failures++;
            $display("FAIL illegal_sticky got ill=%b cnt=%0d exp ill=%b cnt=%0d", bus.illegal, bus.retired_cnt, exp_ill, exp_cnt);
        end
    endtask

    task automatic test_ops();
        logic [4:0]    ops[10] = '{5'd6, 5'd7, 5'd8, 5'd3, 5'd11, 5'd12, 5'd13, 5'd14, 5'd5, 5'd1};
        logic [DW-1:0] src[10] = '{16'hABCD, 16'h1234, 16'h8001, 16'h00FF, 16'hF0F0, 16'h0F00, 16'hC001, 16'h0003, 16'h0000, 16'h7777};
        for (int i = 0; i < 10; i++) begin
            send(ops[i], src[i], 16'h3C3C, 4'(i + 1), 3'(i));
            checks++;
            if (bus.ccr !== exp_ccr) begin
                failures++; $display("FAIL ops_ccr op=%0d got %b exp %b", ops[i], bus.ccr, exp_ccr);
            end
        end
    endtask

    task automatic test_flush();
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        send(5'd4, 16'h0100, 16'h0000, 4'd0, 3'd2);
        bus.flush = 1'b1; bus.in_valid = 1'b1; bus.in_opcode = 5'd9; bus.in_src1 = 16'h0000; bus.in_src2 = 16'h0000;
        #1;
        checks++;
        if (bus.alu_operation !== 13'h0) begin failures++; $display("FAIL flush_alu got %h exp 0", bus.alu_operation); end
        @(posedge clk); #1;
        bus.flush = 1'b0; bus.in_valid = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL flush_held_valid got %b exp 0", bus.out_valid); end
        checks++;
        if (bus.ccr !== exp_ccr || bus.retired_cnt !== exp_cnt) begin
            failures++;
            $display("FAIL flush_state got ccr=%b cnt=%0d exp ccr=%b cnt=%0d", bus.ccr, bus.retired_cnt, exp_ccr, exp_cnt);
        end
        if (sb.size() > 0) void'(sb.pop_back());
        bus.out_ready = 1'b1;
        send(5'd4, 16'h0200, 16'h0000, 4'd0, 3'd3);
        bus.flush = 1'b1; bus.in_valid = 1'b1; bus.in_opcode = 5'd4;
        #1;
        checks++;
        if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL flush_in_ready got %b exp 0", bus.in_ready); end
        @(posedge clk); #1;
        bus.flush = 1'b0; bus.in_valid = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.retired_cnt !== exp_cnt) begin
            failures++;
            $display("FAIL flush_ready_state got valid=%b cnt=%0d exp 0 %0d", bus.out_valid, bus.retired_cnt, exp_cnt);
        end
    endtask

    task automatic test_random();
        logic rnd_done;
        rnd_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 30; i++) begin
                    send(5'($urandom_range(0, 14)), 16'($urandom), 16'($urandom), 4'($urandom), 3'($urandom));
                    checks++;
                    if (bus.ccr !== exp_ccr || bus.retired_cnt !== exp_cnt) begin
                        failures++;
                        $display("FAIL rand_state i=%0d got ccr=%b cnt=%0d exp ccr=%b cnt=%0d",
                                 i, bus.ccr, bus.retired_cnt, exp_ccr, exp_cnt);
                    end
                end
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin @(posedge clk); #1; bus.out_ready = 1'($urandom_range(0, 1)); end
            end
        join
        bus.out_ready = 1'b1;
    endtask

`ifdef CCR_SAVE_EN
    task automatic test_ccr_save();
        send(5'd9, 16'hFFFF, 16'h0002, 4'd0, 3'd1);
        checks++;
        if (bus.ccr !== 3'b100) begin failures++; $display("FAIL save_setup got %b exp 100", bus.ccr); end
        int_save = 1'b1;
        send(5'd9, 16'h0001, 16'h0001, 4'd0, 3'd2);
        int_save = 1'b0;
        checks++;
        if (bus.ccr !== 3'b000) begin failures++; $display("FAIL save_add got %b exp 000", bus.ccr); end
        rti_restore = 1'b1;
        @(posedge clk); #1;
        rti_restore = 1'b0;
        checks++;
        if (bus.ccr !== 3'b100) begin failures++; $display("FAIL rti_restore got %b exp 100", bus.ccr); end
        rti_restore = 1'b1;
        send(5'd9, 16'h0001, 16'h0001, 4'd0, 3'd3);
        rti_restore = 1'b0;
        exp_ccr = 3'b100;
        checks++;
        if (bus.ccr !== 3'b100) begin failures++; $display("FAIL rti_priority got %b exp 100", bus.ccr); end
    endtask
`endif

    task automatic test_reset_mid();
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        send(5'd9, 16'h0003, 16'h0004, 4'd0, 3'd5);
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({bus.out_valid, bus.out_result, bus.out_rdst, bus.out_wb_en, bus.out_port_en,
             bus.ccr, bus.illegal, bus.retired_cnt} !== '0) begin
            failures++;
            $display("FAIL async_reset got valid=%b result=%h ccr=%b ill=%b cnt=%0d exp all 0",
                     bus.out_valid, bus.out_result, bus.ccr, bus.illegal, bus.retired_cnt);
        end
        sb.delete();
        exp_ccr = '0; exp_cnt = '0; exp_ill = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        bus.out_ready = 1'b1;
        send(5'd9, 16'h0002, 16'h0003, 4'd0, 3'd6);
        checks++;
        if (bus.retired_cnt !== 4'd1 || bus.illegal !== 1'b0) begin
            failures++; $display("FAIL post_reset got cnt=%0d ill=%b exp 1 0", bus.retired_cnt, bus.illegal);
        end
    endtask

    initial begin
        bus.flush = 1'b0; bus.in_valid = 1'b0; bus.in_opcode = '0; bus.in_src1 = '0;
        bus.in_src2 = '0; bus.in_shamt = '0; bus.in_rdst = '0; bus.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_add();
        test_sub();
        test_backpressure();
        test_illegal();
        test_ops();
        test_flush();
        test_random();
`ifdef CCR_SAVE_EN
        test_ccr_save();
`endif
        test_reset_mid();
        bus.out_ready = 1'b1;
        for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk);
        #1;
        checks++;
        if (sb.size() != 0) begin failures++; $display("FAIL drain got %0d pending exp 0", sb.size()); end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
